// File: rtl/topk_stream_select.sv
// Streams candidate points, computes squared distance to a latched query in a two-stage
// pipeline and keeps a sorted nearest-first list of up to k_eff (id, distance) entries.
module topk_stream_select #(
    parameter int unsigned DIM     = 2,
    parameter int unsigned COORD_W = 32,
    parameter int unsigned ID_W    = 32,
    parameter int unsigned K       = 5,
    localparam int unsigned DW     = 2*COORD_W + 2 + $clog2(DIM),
    localparam int unsigned KW     = $clog2(K+1)
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   start_in,
    input  logic [DIM*COORD_W-1:0] query_in,
    input  logic [KW-1:0]          k_in,
    input  logic [DIM*COORD_W-1:0] vertex_in,
    input  logic [ID_W-1:0]        vertex_id_in,
    input  logic                   vertex_valid_in,
    input  logic                   vertex_last_in,
    output logic                   vertex_ready_out,
    output logic [K*ID_W-1:0]      top_k_id_out,
    output logic [K*DW-1:0]        top_k_dist_out,
    output logic [KW-1:0]          count_out,
    output logic                   busy_out,
    output logic                   valid_out
);

    localparam int unsigned DIFF_W = COORD_W + 1;
    localparam int unsigned SQ_W   = 2*DIFF_W;
    localparam int unsigned PW     = DIM*COORD_W;

    typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DRAIN, ST_DONE} state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      query_q, query_d;
    logic [KW-1:0]      k_eff_q, k_eff_d;
    logic [KW-1:0]      count_q, count_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    logic [SQ_W-1:0]    s1_sq_q [DIM];
    logic [SQ_W-1:0]    s1_sq_d [DIM];
    logic [ID_W-1:0]    s1_id_q, s1_id_d;
    logic               s1_vld_q, s1_vld_d;
    logic [DW-1:0]      s2_dist_q, s2_dist_d;
    logic [ID_W-1:0]    s2_id_q, s2_id_d;
    logic               s2_vld_q, s2_vld_d;
    logic [ID_W-1:0]    id_q [K];
    logic [ID_W-1:0]    id_d [K];
    logic [DW-1:0]      dist_q [K];
    logic [DW-1:0]      dist_d [K];

    logic               accept_c;
    logic [K-1:0]       le_c;
    logic [K-1:0]       in_k_c;
    logic signed [DIFF_W-1:0] diff_c;
    logic signed [SQ_W-1:0]   dext_c;

    assign accept_c = vertex_valid_in && ready_q;

    // Stage 1: per-coordinate signed difference squared (always non-negative)
    always_comb begin
        diff_c = '0;
        dext_c = '0;
        for (int d = 0; d < DIM; d++) begin
            diff_c     = DIFF_W'($signed(vertex_in[d*COORD_W +: COORD_W]))
                       - DIFF_W'($signed(query_q[d*COORD_W +: COORD_W]));
            dext_c     = SQ_W'(diff_c);
            s1_sq_d[d] = SQ_W'(dext_c * dext_c);
        end
    end

    // le_c is a prefix mask over the sorted list; its population is the insert position
    always_comb begin
        for (int i = 0; i < K; i++) begin
            le_c[i]   = (dist_q[i] <= s2_dist_q);
            in_k_c[i] = (KW'(i) < k_eff_q);
        end
    end

    always_comb begin
        state_d  = state_q;
        query_d  = query_q;
        k_eff_d  = k_eff_q;
        count_d  = count_q;
        s1_id_d  = vertex_id_in;
        s1_vld_d = accept_c;
        s2_id_d  = s1_id_q;
        s2_vld_d = s1_vld_q;
        s2_dist_d = '0;
        for (int d = 0; d < DIM; d++) begin
            s2_dist_d = s2_dist_d + DW'(s1_sq_q[d]);
        end
        for (int i = 0; i < K; i++) begin
            id_d[i]   = id_q[i];
            dist_d[i] = dist_q[i];
        end

        // One-cycle insertion: keep entries at or above the new one, shift the rest down
        if (s2_vld_q) begin
            if (in_k_c[0] && !le_c[0]) begin
                id_d[0]   = s2_id_q;
                dist_d[0] = s2_dist_q;
            end
            for (int i = 1; i < K; i++) begin
                if (in_k_c[i] && !le_c[i]) begin
                    id_d[i]   = le_c[i-1] ? s2_id_q   : id_q[i-1];
                    dist_d[i] = le_c[i-1] ? s2_dist_q : dist_q[i-1];
                end
            end
            if (count_q < k_eff_q) begin
                count_d = count_q + KW'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    state_d = ST_STREAM;
                    query_d = query_in;
                    k_eff_d = (k_in == '0 || k_in > KW'(K)) ? KW'(K) : k_in;
                    count_d = '0;
                    for (int i = 0; i < K; i++) begin
                        id_d[i]   = '0;
                        dist_d[i] = '1;
                    end
                end
            end
            ST_STREAM: begin
                if (accept_c && vertex_last_in) begin
                    state_d = ST_DRAIN;
                end
            end
            // Stage 1 empty means the last beat sits in stage 2 and inserts this edge
            ST_DRAIN: begin
                if (!s1_vld_q) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_STREAM);
        busy_d  = (state_d != ST_IDLE);
        valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= ST_IDLE;
            query_q   <= '0;
            k_eff_q   <= KW'(K);
            count_q   <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            s1_id_q   <= '0;
            s1_vld_q  <= 1'b0;
            s2_dist_q <= '0;
            s2_id_q   <= '0;
            s2_vld_q  <= 1'b0;
            for (int d = 0; d < DIM; d++) begin
                s1_sq_q[d] <= '0;
            end
            for (int i = 0; i < K; i++) begin
                id_q[i]   <= '0;
                dist_q[i] <= '1;
            end
        end else begin
            state_q   <= state_d;
            query_q   <= query_d;
            k_eff_q   <= k_eff_d;
            count_q   <= count_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            s1_id_q   <= s1_id_d;
            s1_vld_q  <= s1_vld_d;
            s2_dist_q <= s2_dist_d;
            s2_id_q   <= s2_id_d;
            s2_vld_q  <= s2_vld_d;
            for (int d = 0; d < DIM; d++) begin
                s1_sq_q[d] <= s1_sq_d[d];
            end
            for (int i = 0; i < K; i++) begin
                id_q[i]   <= id_d[i];
                dist_q[i] <= dist_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < K; i++) begin
            top_k_id_out[i*ID_W +: ID_W] = id_q[i];
            top_k_dist_out[i*DW +: DW]   = dist_q[i];
        end
    end

    assign vertex_ready_out = ready_q;
    assign count_out        = count_q;
    assign busy_out         = busy_q;
    assign valid_out        = valid_q;

endmodule

// File: tb/tb_topk_stream_select.sv
// Directed bench for topk_stream_select: table of runs with hand-computed sorted lists,
// plus hand sequences for mid-run reset and ignored start/valid while busy.
module tb_topk_stream_select;

    localparam int unsigned DIM = 2;
    localparam int unsigned CW  = 32;
    localparam int unsigned IW  = 32;
    localparam int unsigned K   = 5;
    localparam int unsigned DW  = 2*CW + 2 + 1;
    localparam int unsigned KW  = 3;
    localparam int unsigned NV  = 6;
    localparam logic [DW-1:0] DMAX = '1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start_in;
    logic [DIM*CW-1:0]    query_in;
    logic [KW-1:0]        k_in;
    logic [DIM*CW-1:0]    vertex_in;
    logic [IW-1:0]        vertex_id_in;
    logic                 vertex_valid_in;
    logic                 vertex_last_in;
    logic                 vertex_ready_out;
    logic [K*IW-1:0]      top_k_id_out;
    logic [K*DW-1:0]      top_k_dist_out;
    logic [KW-1:0]        count_out;
    logic                 busy_out;
    logic                 valid_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    topk_stream_select #(.DIM(DIM), .COORD_W(CW), .ID_W(IW), .K(K)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start_in), .query_in(query_in),
        .k_in(k_in), .vertex_in(vertex_in), .vertex_id_in(vertex_id_in),
        .vertex_valid_in(vertex_valid_in), .vertex_last_in(vertex_last_in),
        .vertex_ready_out(vertex_ready_out), .top_k_id_out(top_k_id_out),
        .top_k_dist_out(top_k_dist_out), .count_out(count_out),
        .busy_out(busy_out), .valid_out(valid_out)
    );

    typedef struct packed {
        logic [31:0]             qx, qy;
        logic [KW-1:0]           k;
        logic [3:0]              n;
        logic [5:0][31:0]        vx, vy, vid;
        logic [4:0][31:0]        eid;
        logic [4:0][DW-1:0]      edist;
        logic [KW-1:0]           ecnt;
    } vec_t;

    vec_t vecs [NV];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic new_vec(input int v, input logic [31:0] qx, input logic [31:0] qy,
                           input logic [KW-1:0] k, input logic [KW-1:0] ecnt);
        vecs[v] = '0;
        vecs[v].qx = qx;
        vecs[v].qy = qy;
        vecs[v].k = k;
        vecs[v].ecnt = ecnt;
        for (int i = 0; i < 5; i++) vecs[v].edist[i] = DMAX;
    endtask

    task automatic beat(input int v, input logic [31:0] x, input logic [31:0] y, input int id);
        int j;
        j = int'(vecs[v].n);
        vecs[v].vx[j] = x;
        vecs[v].vy[j] = y;
        vecs[v].vid[j] = 32'(id);
        vecs[v].n = 4'(j + 1);
    endtask

    task automatic ent(input int v, input int i, input int id, input logic [DW-1:0] d);
        vecs[v].eid[i] = 32'(id);
        vecs[v].edist[i] = d;
    endtask

    task automatic check_list(input string tag, input vec_t tv);
        for (int i = 0; i < K; i++) begin
            chk($sformatf("%s_id%0d", tag, i), 128'(top_k_id_out[i*IW +: IW]), 128'(tv.eid[i]));
            chk($sformatf("%s_dist%0d", tag, i), 128'(top_k_dist_out[i*DW +: DW]), 128'(tv.edist[i]));
        end
        chk({tag, "_count"}, 128'(count_out), 128'(tv.ecnt));
    endtask

    // Waits for the done pulse; cycle 1 is the cycle right after the last beat's cycle
    task automatic wait_done(input string tag);
        int cyc;
        cyc = 1;
        chk({tag, "_drain_ready"}, 128'(vertex_ready_out), 128'(0));
        chk({tag, "_drain_busy"}, 128'(busy_out), 128'(1));
        while (!valid_out && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done_cycle"}, 128'(cyc), 128'(3));
    endtask

    task automatic run_vec(input string tag, input vec_t tv);
        @(negedge clk);
        start_in = 1'b1;
        query_in = {tv.qy, tv.qx};
        k_in = tv.k;
        @(negedge clk);
        start_in = 1'b0;
        chk({tag, "_stream_ready"}, 128'(vertex_ready_out), 128'(1));
        chk({tag, "_cleared_dist0"}, 128'(top_k_dist_out[DW-1:0]), 128'(DMAX));
        chk({tag, "_cleared_count"}, 128'(count_out), 128'(0));
        for (int j = 0; j < int'(tv.n); j++) begin
            vertex_in = {tv.vy[j], tv.vx[j]};
            vertex_id_in = tv.vid[j];
            vertex_valid_in = 1'b1;
            vertex_last_in = (j == int'(tv.n) - 1);
            @(negedge clk);
        end
        vertex_valid_in = 1'b0;
        vertex_last_in = 1'b0;
        wait_done(tag);
        check_list(tag, tv);
        @(negedge clk);
        chk({tag, "_valid_pulse"}, 128'(valid_out), 128'(0));
        chk({tag, "_idle_busy"}, 128'(busy_out), 128'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        start_in = 1'b0;
        query_in = '0;
        k_in = '0;
        vertex_in = '0;
        vertex_id_in = '0;
        vertex_valid_in = 1'b0;
        vertex_last_in = 1'b0;

        new_vec(0, 0, 0, 3, 3);
        beat(0, 3, 4, 1); beat(0, 1, 1, 2); beat(0, 0, 2, 3); beat(0, 5, 0, 4); beat(0, 1, 0, 5);
        ent(0, 0, 5, 1); ent(0, 1, 2, 2); ent(0, 2, 3, 4);

        new_vec(1, 0, 0, 2, 2);
        beat(1, 1, 1, 7); beat(1, 1, 1, 8); beat(1, 1, 1, 9);
        ent(1, 0, 7, 2); ent(1, 1, 8, 2);

        new_vec(2, 0, 0, 5, 2);
        beat(2, 2, 0, 1); beat(2, 0, 1, 2);
        ent(2, 0, 2, 1); ent(2, 1, 1, 4);

        new_vec(3, 32'h8000_0000, 0, 1, 1);
        beat(3, 32'h7FFF_FFFF, 0, 42);
        ent(3, 0, 42, DW'(64'hFFFF_FFFE_0000_0001));

        // k_in = 0 selects full depth; the farthest of six is pushed out
        new_vec(4, 10, -10, 0, 5);
        beat(4, 10, -10, 1); beat(4, 13, -6, 2); beat(4, 9, -10, 3);
        beat(4, 10, -8, 4); beat(4, 7, -10, 5); beat(4, 10, -9, 6);
        ent(4, 0, 1, 0); ent(4, 1, 3, 1); ent(4, 2, 6, 1); ent(4, 3, 4, 4); ent(4, 4, 5, 9);

        // k_in above K clamps; arrivals in descending distance each land at the head
        new_vec(5, 0, 0, 7, 5);
        for (int i = 6; i >= 1; i--) beat(5, 0, 32'(i), 20 + i);
        for (int i = 0; i < 5; i++) ent(5, i, 21 + i, DW'((i + 1) * (i + 1)));

        #12;
        chk("rst_ready", 128'(vertex_ready_out), 128'(0));
        chk("rst_busy", 128'(busy_out), 128'(0));
        chk("rst_valid", 128'(valid_out), 128'(0));
        chk("rst_count", 128'(count_out), 128'(0));
        chk("rst_ids", 128'(top_k_id_out), 128'(0));
        for (int i = 0; i < K; i++)
            chk($sformatf("rst_dist%0d", i), 128'(top_k_dist_out[i*DW +: DW]), 128'(DMAX));
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < NV; v++) run_vec($sformatf("vec%0d", v), vecs[v]);

        // Mid-run reset: first beat has just landed when reset hits
        @(negedge clk);
        start_in = 1'b1;
        query_in = '0;
        k_in = 3'd5;
        @(negedge clk);
        start_in = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            vertex_in = {32'd0, 32'(j)};
            vertex_id_in = 32'(30 + j);
            vertex_valid_in = 1'b1;
            @(negedge clk);
        end
        vertex_valid_in = 1'b0;
        chk("pre_reset_count", 128'(count_out), 128'(1));
        chk("pre_reset_id0", 128'(top_k_id_out[IW-1:0]), 128'(31));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 128'(busy_out), 128'(0));
        chk("mid_rst_ready", 128'(vertex_ready_out), 128'(0));
        chk("mid_rst_count", 128'(count_out), 128'(0));
        chk("mid_rst_id0", 128'(top_k_id_out[IW-1:0]), 128'(0));
        chk("mid_rst_dist0", 128'(top_k_dist_out[DW-1:0]), 128'(DMAX));
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("after_rst", vecs[2]);

        // start_in while busy and a beat offered during drain must both be ignored
        @(negedge clk);
        start_in = 1'b1;
        query_in = '0;
        k_in = 3'd2;
        @(negedge clk);
        query_in = {32'd0, 32'd100};
        k_in = 3'd1;
        vertex_in = {32'd0, 32'd1};
        vertex_id_in = 32'd1;
        vertex_valid_in = 1'b1;
        @(negedge clk);
        vertex_in = {32'd0, 32'd2};
        vertex_id_in = 32'd2;
        vertex_last_in = 1'b1;
        @(negedge clk);
        vertex_in = '0;
        vertex_id_in = 32'd99;
        wait_done("ignore");
        start_in = 1'b0;
        vertex_valid_in = 1'b0;
        vertex_last_in = 1'b0;
        chk("ignore_id0", 128'(top_k_id_out[0 +: IW]), 128'(1));
        chk("ignore_id1", 128'(top_k_id_out[IW +: IW]), 128'(2));
        chk("ignore_dist0", 128'(top_k_dist_out[0 +: DW]), 128'(1));
        chk("ignore_dist1", 128'(top_k_dist_out[DW +: DW]), 128'(4));
        chk("ignore_id2", 128'(top_k_id_out[2*IW +: IW]), 128'(0));
        chk("ignore_count", 128'(count_out), 128'(2));
        repeat (4) @(negedge clk);
        chk("held_id0", 128'(top_k_id_out[0 +: IW]), 128'(1));
        chk("held_count", 128'(count_out), 128'(2));
        chk("held_busy", 128'(busy_out), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
